// File: rtl/demux_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : demux_pkg                                             |
// | Brief    : Shared constants and slot state type for stream_demux |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package demux_pkg;

  localparam int DEF_DW  = 8;
  localparam int DEF_NCH = 4;

  // One-entry slot occupancy
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/demux_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : demux_slot                                            |
// | Brief    : One-entry holding register for a single output        |
// |            channel. A load always wins over a drain, so a slot   |
// |            being emptied and refilled in the same cycle stays    |
// |            FULL with the new word.                               |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module demux_slot
  import demux_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          take,
  output logic [DW-1:0] data,
  output logic          valid,
  output logic          free
);

  slot_state_t state;

  // Occupancy and payload; payload only changes on a load so it holds while FULL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      data  <= '0;
    end else if (load) begin
      state <= FULL;
      data  <= load_data;
    end else if (state == FULL && take) begin
      state <= EMPTY;
    end
  end

  assign valid = (state == FULL);
  // Free this cycle if empty or the held word is leaving right now
  assign free  = (state == EMPTY) || take;

endmodule
`default_nettype wire

// File: rtl/stream_demux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : stream_demux                                          |
// | Brief    : Routes a valid/ready stream to one of NCH channels,   |
// |            each with a one-entry slot. Out-of-range selects are  |
// |            accepted, discarded and counted.                      |
// | Options  : STREAM_DEMUX_BCAST_EN adds in_bcast, which loads the  |
// |            word into every channel at once.                      |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module stream_demux
  import demux_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int NCH = DEF_NCH,
  parameter int SW  = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic              in_bcast,
`endif
  output logic              err_sel,
  output logic [7:0]        drop_cnt
);

  // Free vector padded to the full select range so any in_sel indexes safely
  localparam int            NPAD  = 1 << SW;
  localparam logic [SW:0]   NCH_W = (SW+1)'(NCH);

  logic            bcast;
  logic [NCH-1:0]  slot_free;
  logic [NCH-1:0]  slot_load;
  logic [NPAD-1:0] free_pad;
  logic            sel_ok;
  logic            ready_sel;
  logic            accept;
  logic            drop;

`ifdef STREAM_DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  assign free_pad  = NPAD'(slot_free);
  assign sel_ok    = ({1'b0, in_sel} < NCH_W);
  // Bad selects are always taken so they can never stall the stream
  assign ready_sel = sel_ok ? free_pad[in_sel] : 1'b1;
  assign in_ready  = bcast ? (&slot_free) : ready_sel;
  assign accept    = in_valid && in_ready;
  assign drop      = accept && !bcast && !sel_ok;

  for (genvar k = 0; k < NCH; k++) begin : g_slot
    assign slot_load[k] = accept && (bcast || (in_sel == SW'(k)));

    demux_slot #(
      .DW(DW)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slot_load[k]),
      .load_data (in_data),
      .take      (out_ready[k]),
      .data      (out_data[k*DW +: DW]),
      .valid     (out_valid[k]),
      .free      (slot_free[k])
    );
  end

  // Error pulse one cycle after a discarded word; drop counter saturates at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sel  <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      err_sel <= drop;
      if (drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_demux.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_stream_demux                                       |
// | Brief    : Self-checking bench for stream_demux; one NCH=4 and   |
// |            one NCH=3 instance against a per-channel slot model.  |
// |            Broadcast scenario is active with                     |
// |            STREAM_DEMUX_BCAST_EN.                                |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [7:0] idata [2];
  logic [1:0] isel  [2];
  logic       ivalid[2];
  logic [3:0] ordy  [2];
  logic       bc;

  logic        rdy4, rdy3, err4, err3;
  logic [3:0]  ov4;
  logic [2:0]  ov3;
  logic [31:0] od4;
  logic [23:0] od3;
  logic [7:0]  drop4, drop3;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  stream_demux #(.DW(8), .NCH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(idata[0]), .in_sel(isel[0]),
    .in_valid(ivalid[0]), .in_ready(rdy4), .out_data(od4), .out_valid(ov4),
    .out_ready(ordy[0]),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(bc),
`endif
    .err_sel(err4), .drop_cnt(drop4)
  );

  stream_demux #(.DW(8), .NCH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(idata[1]), .in_sel(isel[1]),
    .in_valid(ivalid[1]), .in_ready(rdy3), .out_data(od3), .out_valid(ov3),
    .out_ready(ordy[1][2:0]),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast(1'b0),
`endif
    .err_sel(err3), .drop_cnt(drop3)
  );

  // ---------------- behavioural model ----------------
  logic       m_full[2][4];
  logic [7:0] m_data[2][4];
  logic       m_err [2];
  int         m_drop[2];

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic m_ready(input int d);
    int n = nch(d);
    if (d == 0 && bc) begin
      for (int k = 0; k < 4; k++)
        if (m_full[0][k] && !ordy[0][k]) return 1'b0;
      return 1'b1;
    end
    if (int'(isel[d]) >= n) return 1'b1;
    return !m_full[d][isel[d]] || ordy[d][isel[d]];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 4; k++) begin
          m_full[d][k] = 1'b0;
          m_data[d][k] = 8'h00;
        end
        m_err[d]  = 1'b0;
        m_drop[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic acc, b;
        acc = ivalid[d] && m_ready(d);
        b   = (d == 0) && bc;
        for (int k = 0; k < nch(d); k++) begin
          if (acc && (b || int'(isel[d]) == k)) begin
            m_full[d][k] = 1'b1;
            m_data[d][k] = idata[d];
          end else if (m_full[d][k] && ordy[d][k]) begin
            m_full[d][k] = 1'b0;
          end
        end
        m_err[d] = acc && !b && (int'(isel[d]) >= nch(d));
        if (m_err[d] && m_drop[d] < 255) m_drop[d] = m_drop[d] + 1;
      end
    end
  end

  task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s (dut%0d) at %0t: got %0h expected %0h", name, d, $time, act, exp);
    end
  endtask

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0]  aov;
        logic [31:0] aod;
        logic        ardy, aerr;
        logic [7:0]  adrop;
        if (d == 0) begin
          aov = ov4; aod = od4; ardy = rdy4; aerr = err4; adrop = drop4;
        end else begin
          aov = {1'b0, ov3}; aod = {8'h00, od3}; ardy = rdy3; aerr = err3; adrop = drop3;
        end
        check("in_ready", d, 64'(ardy), 64'(m_ready(d)));
        for (int k = 0; k < nch(d); k++) begin
          check("out_valid", d, 64'(aov[k]), 64'(m_full[d][k]));
          check("out_data", d, 64'(aod[k*8 +: 8]), 64'(m_data[d][k]));
        end
        check("err_sel", d, 64'(aerr), 64'(m_err[d]));
        check("drop_cnt", d, 64'(adrop), 64'(m_drop[d]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      ivalid[d] = 1'b0; isel[d] = 2'd0; idata[d] = 8'h00; ordy[d] = 4'hF;
    end
    bc = 1'b0;
  endtask

  initial begin
    int errs;
    logic anyv;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 0, 64'(ov4), 64'h0);
    check("rst_out_data", 0, 64'(od4), 64'h0);
    check("rst_drop", 1, 64'(drop3), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;
    cyc();

    // Routing: word 0xA5 to channel 2
    isel[0] = 2'd2; idata[0] = 8'hA5; ivalid[0] = 1'b1;
    cyc();
    ivalid[0] = 1'b0;
    check("route_valid", 0, 64'(ov4), 64'h4);
    check("route_data", 0, 64'(od4[23:16]), 64'hA5);
    cyc();

    // Backpressure on channel 1
    ordy[0] = 4'b1101;
    isel[0] = 2'd1; idata[0] = 8'h11; ivalid[0] = 1'b1;
    #1 check("bp_first_ready", 0, 64'(rdy4), 64'h1);
    cyc();
    idata[0] = 8'h22;
    #1 check("bp_second_ready", 0, 64'(rdy4), 64'h0);
    cyc();
    check("bp_hold_data", 0, 64'(od4[15:8]), 64'h11);
    ordy[0] = 4'hF;
    #1 check("bp_ready_release", 0, 64'(rdy4), 64'h1);
    cyc();
    ivalid[0] = 1'b0;
    check("bp_second_valid", 0, 64'(ov4[1]), 64'h1);
    check("bp_second_data", 0, 64'(od4[15:8]), 64'h22);
    cyc();
    check("bp_drained", 0, 64'(ov4[1]), 64'h0);

    // Independence: ch0 stalled full, word to ch3 still flows
    ordy[0] = 4'b1110;
    isel[0] = 2'd0; idata[0] = 8'h77; ivalid[0] = 1'b1;
    cyc();
    isel[0] = 2'd3; idata[0] = 8'h33;
    #1 check("indep_ready", 0, 64'(rdy4), 64'h1);
    cyc();
    ivalid[0] = 1'b0;
    check("indep_valid", 0, 64'(ov4), 64'h9);
    check("indep_data", 0, 64'(od4[31:24]), 64'h33);
    ordy[0] = 4'hF;
    cyc();

    // Bad select on NCH=3: 300 discarded words
    errs = 0; anyv = 1'b0;
    isel[1] = 2'd3; ivalid[1] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      idata[1] = 8'($urandom);
      cyc();
      errs += int'(err3);
      anyv |= |ov3;
    end
    ivalid[1] = 1'b0;
    check("bad_err_pulses", 1, 64'(errs), 64'd300);
    check("bad_drop_sat", 1, 64'(drop3), 64'd255);
    check("bad_no_valid", 1, 64'(anyv), 64'h0);
    cyc();

`ifdef STREAM_DEMUX_BCAST_EN
    // Broadcast blocked by stalled ch2 until it drains
    ordy[0] = 4'b1011;
    isel[0] = 2'd2; idata[0] = 8'h44; ivalid[0] = 1'b1;
    cyc();
    bc = 1'b1; idata[0] = 8'h5A; isel[0] = 2'd0;
    #1 check("bc_blocked", 0, 64'(rdy4), 64'h0);
    cyc();
    check("bc_still_blocked", 0, 64'(rdy4), 64'h0);
    ordy[0] = 4'hF;
    #1 check("bc_ready", 0, 64'(rdy4), 64'h1);
    cyc();
    ivalid[0] = 1'b0; bc = 1'b0;
    check("bc_valid", 0, 64'(ov4), 64'hF);
    check("bc_data", 0, 64'(od4), 64'h5A5A5A5A);
    cyc();
`endif

    // Reset mid-burst
    ordy[0] = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      isel[0] = 2'(i); idata[0] = 8'($urandom); ivalid[0] = 1'b1;
      cyc();
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 0, 64'(ov4), 64'h0);
    check("arst_out_data", 0, 64'(od4), 64'h0);
    check("arst_drop", 1, 64'(drop3), 64'h0);
    cyc();
    isel[0] = 2'd0; idata[0] = 8'hC3; ivalid[0] = 1'b1;
    #2 rst_n = 1'b1;
    cyc();
    ivalid[0] = 1'b0;
    check("post_rst_valid", 0, 64'(ov4[0]), 64'h1);
    check("post_rst_data", 0, 64'(od4[7:0]), 64'hC3);
    ordy[0] = 4'hF;
    cyc();

    // Random traffic on both instances
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++) begin
        ivalid[d] = ($urandom_range(0, 3) != 0);
        isel[d]   = 2'($urandom_range(0, 3));
        idata[d]  = 8'($urandom);
        ordy[d]   = 4'($urandom);
      end
`ifdef STREAM_DEMUX_BCAST_EN
      bc = ($urandom_range(0, 5) == 0);
`endif
      cyc();
    end
    idle();
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width in bits.
REQ-002 SHALL have parameter NCH, default 4, meaning number of output channels (2..16).
REQ-003 SHALL have parameter SW, default $clog2(NCH), meaning select width; it is derived and not overridden.
REQ-004 SHALL have port clk  input  1  system clock; one clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  DW  payload to route.
REQ-007 SHALL have port in_sel  input  SW  destination channel index.
REQ-008 SHALL have port in_valid  input  1  upstream offers a word.
REQ-009 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-010 SHALL have port out_data  output  NCH*DW  per-channel payload; channel k occupies bits [k*DW +: DW].
REQ-011 SHALL have port out_valid  output  NCH  per-channel word held.
REQ-012 SHALL have port out_ready  input  NCH  per-channel downstream accepts.
REQ-013 SHALL have port err_sel  output  1  one-cycle pulse on an accepted word with in_sel >= NCH.
REQ-014 SHALL have port drop_cnt  output  8  saturating count of dropped words.

Function
REQ-015 Each channel SHALL hold a one-entry slot: EMPTY (out_valid=0) or FULL (out_valid=1).
REQ-016 Input transfer = in_valid && in_ready; output transfer k = out_valid[k] && out_ready[k].
REQ-017 For in_sel < NCH, in_ready SHALL be 1 when slot in_sel is EMPTY or performs an output transfer in the same cycle; it is combinational from the slot state and out_ready only, never from in_valid.
REQ-018 An accepted word SHALL appear on out_data/out_valid of channel in_sel on the next cycle (1-cycle latency); the other channels are unchanged.
REQ-019 Simultaneous output and input transfer on the same slot SHALL leave it FULL with the new word, giving full throughput of 1 word/cycle per channel.
REQ-020 Output transfer without input transfer SHALL return the slot to EMPTY; out_data of an EMPTY slot SHALL hold its last value.
REQ-021 For in_sel >= NCH (possible only when NCH is not a power of 2), in_ready SHALL be 1; the word is discarded, err_sel pulses next cycle, and drop_cnt increments, saturating at 255.
REQ-022 Once out_valid[k] is 1, out_data[k] SHALL stay stable until output transfer k.
REQ-023 A full slot on one channel SHALL NOT block words addressed to other channels.

Reset
REQ-024 While rst_n=0, all out_valid SHALL be 0, out_data SHALL be 0, err_sel SHALL be 0, and drop_cnt SHALL be 0, asynchronously.
REQ-025 Reset mid-operation SHALL discard all held words; the first accept after release SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-026 Macro STREAM_DEMUX_BCAST_EN defined: the block SHALL add port in_bcast (input, 1).
- When in_bcast=1, in_sel is ignored.
- in_ready SHALL be 1 only when every slot is EMPTY or transferring out that cycle.
- The accepted word SHALL load all NCH slots together.
- err_sel and drop_cnt SHALL be unaffected.
REQ-027 Macro not defined: in_bcast SHALL be absent, and behaviour SHALL equal in_bcast=0.

Structure
REQ-028 Package demux_pkg SHALL hold the default DW/NCH constants and the slot state enum (EMPTY, FULL).
REQ-029 The per-channel slot SHALL be sub-module demux_slot, instantiated NCH times by a generate loop; routing, ready, and the error/drop logic stay in the top module.

Verification
REQ-030 The bench SHALL cover these scenarios:
- Reset: assert rst_n=0 mid-burst -> out_valid=0, drop_cnt=0 immediately; accept at first edge after release.
- Routing: NCH=4, in_sel=2, in_data=0xA5, all out_ready=1 -> next cycle out_valid=4'b0100 and channel 2 data=0xA5.
- Backpressure: out_ready[1]=0, two words to ch1 -> second sees in_ready=0; raise out_ready[1] -> 0x11 then 0x22 delivered in order, 1/cycle.
- Independence: ch0 FULL and stalled, word to ch3 -> in_ready=1, delivered next cycle.
- Bad select: NCH=3, in_sel=3 repeated 300 times -> 300 err_sel pulses, drop_cnt=255, no out_valid.
- Broadcast (macro on): in_bcast=1, 0x5A, ch2 stalled FULL -> in_ready=0 until ch2 drains, then all 4 channels show 0x5A.
